circle_decoder: RTL and testbench

- Receive-side counterpart of the walking-circle animation.
- Samples the multi-display 7-segment bus and decodes the single lit circle into column, row and direction.
- Checks every step against the legal walk pattern, counts completed laps and flags protocol violations.
- Used as an on-chip self-check and loopback monitor beside the display driver.

---
 rtl/circle_pkg.sv | 23 ++
 rtl/circle_glyph_decode.sv | 25 ++
 rtl/circle_decoder.sv | 186 ++++++++++++++++++
 tb/tb_circle_decoder.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/circle_pkg.sv
// Shared types and constants for the walking-circle receive monitor.
//   glyph_e    : per-digit classification of a 7-segment pattern
//   err_code_e : first-error code reported on err_code_o
//   state_e    : decoder FSM states
//   UPPER_MASK / LOWER_MASK : lit-segment patterns {dp,g,f,e,d,c,b,a}
package circle_pkg;

  typedef enum logic [1:0] {BLANK, UPPER, LOWER, BAD} glyph_e;

  typedef enum logic [1:0] {
    ERR_GLYPH = 2'd0,
    ERR_MULTI = 2'd1,
    ERR_NONE  = 2'd2,
    ERR_JUMP  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {ST_ACQUIRE, ST_SYNC, ST_TRACK, ST_ERROR} state_e;

  // Upper circle lights a,b,f,g; lower circle lights c,d,e,g.
  localparam logic [7:0] UPPER_MASK = 8'h63;
  localparam logic [7:0] LOWER_MASK = 8'h5C;

endpackage

// File: rtl/circle_glyph_decode.sv
// Combinational classifier for one 7-segment digit.
//   seg_i   : raw segment bits {dp,g,f,e,d,c,b,a} as seen on the bus
//   glyph_o : BLANK / UPPER / LOWER / BAD (the decimal point is ignored)
import circle_pkg::*;

module circle_glyph_decode #(
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic [7:0] seg_i,
  output glyph_e     glyph_o
);

  logic [7:0] lit;

  // Normalise to "1 = lit" and drop dp before matching.
  assign lit = (LED_ACTIVE_LOW ? ~seg_i : seg_i) & 8'h7F;

  always_comb begin
    glyph_o = BAD;
    if (lit == 8'h00)           glyph_o = BLANK;
    else if (lit == UPPER_MASK) glyph_o = UPPER;
    else if (lit == LOWER_MASK) glyph_o = LOWER;
  end

endmodule

// File: rtl/circle_decoder.sv
// Receive-side monitor for the walking-circle animation. Decodes the lit
// circle on a multi-digit 7-segment bus, checks each step against the
// legal walk, counts laps and latches the first protocol error.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   sample_i           : decode the bus this cycle
//   clr_err_i          : clear error/lap count, restart acquisition
//   seg7_i             : segment bus, one byte per digit
//   valid_o            : tracking, col/row/dir meaningful
//   col_o, row_o, dir_o: position (row 1 = upper) and walk direction
//   step_o, lap_o      : one-cycle pulses on a legal move / completed lap
//   lap_count_o        : completed laps (wrapping)
//   error_o, err_code_o: sticky error and code of the first error
import circle_pkg::*;

module circle_decoder #(
  parameter int NUM_OF_DISPLAYS = 6,
  parameter int COL_WIDTH       = $clog2(NUM_OF_DISPLAYS),
  parameter bit LED_ACTIVE_LOW  = 1'b1,
  parameter int LAP_WIDTH       = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sample_i,
  input  logic                             clr_err_i,
  input  logic [NUM_OF_DISPLAYS-1:0][7:0]  seg7_i,
  output logic                             valid_o,
  output logic [COL_WIDTH-1:0]             col_o,
  output logic                             row_o,
  output logic                             dir_o,
  output logic                             step_o,
  output logic                             lap_o,
  output logic [LAP_WIDTH-1:0]             lap_count_o,
  output logic                             error_o,
  output logic [1:0]                       err_code_o
);

  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(NUM_OF_DISPLAYS - 1);

  glyph_e glyph [NUM_OF_DISPLAYS];

  for (genvar g = 0; g < NUM_OF_DISPLAYS; g++) begin : g_dec
    circle_glyph_decode #(.LED_ACTIVE_LOW(LED_ACTIVE_LOW)) u_dec (
      .seg_i   (seg7_i[g]),
      .glyph_o (glyph[g])
    );
  end

  // ---------------- frame decode ----------------
  logic                 any_bad;
  logic [1:0]           n_lit;     // saturates at 2, only 0/1/many matter
  logic [COL_WIDTH-1:0] frm_col;
  logic                 frm_row;
  logic                 frm_ok;
  err_code_e            frm_code;

  always_comb begin
    any_bad = 1'b0;
    n_lit   = 2'd0;
    frm_col = '0;
    frm_row = 1'b0;
    for (int i = 0; i < NUM_OF_DISPLAYS; i++) begin
      if (glyph[i] == BAD) begin
        any_bad = 1'b1;
      end else if (glyph[i] != BLANK) begin
        if (n_lit != 2'd2) n_lit = n_lit + 2'd1;
        frm_col = COL_WIDTH'(i);
        frm_row = (glyph[i] == UPPER);
      end
    end
    frm_ok   = !any_bad && (n_lit == 2'd1);
    frm_code = any_bad ? ERR_GLYPH : (n_lit == 2'd2) ? ERR_MULTI : ERR_NONE;
  end

  // ---------------- move classification vs. previous position ----------------
  state_e               state_q;
  logic [COL_WIDTH-1:0] col_q;
  logic                 row_q, dir_q, step_q, lap_q, valid_q, err_q;
  logic [LAP_WIDTH-1:0] lap_cnt_q;
  err_code_e            code_q;

  logic same_row, is_hold, is_inc, is_dec, is_flip, at_first, at_last;
  logic sync_ok, sync_dir_d, track_ok, lap_turn;
  err_code_e err_code_d;

  always_comb begin
    same_row  = (frm_row == row_q);
    at_first  = (col_q == '0);
    at_last   = (col_q == LAST_COL);
    is_hold   = same_row && (frm_col == col_q);
    is_inc    = same_row && !at_last  && (frm_col == col_q + COL_WIDTH'(1));
    is_dec    = same_row && !at_first && (frm_col == col_q - COL_WIDTH'(1));
    is_flip   = !same_row && (frm_col == col_q);
    // SYNC has no direction yet, so any adjacent move or end-column flip is accepted
    sync_ok   = is_inc || is_dec || (is_flip && (at_first || at_last));
    sync_dir_d = is_inc || (is_flip && at_first);
    track_ok  = (is_inc && dir_q) || (is_dec && !dir_q) ||
                (is_flip && ((dir_q && at_last) || (!dir_q && at_first)));
    // a lap closes when the walk turns from the upper to the lower circle at column 0
    lap_turn  = is_flip && at_first && row_q && !frm_row;
    err_code_d = frm_ok ? ERR_JUMP : frm_code;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_ACQUIRE;
      col_q     <= '0;
      row_q     <= 1'b0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      lap_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_GLYPH;
      lap_cnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      lap_q  <= 1'b0;
      if (clr_err_i) begin
        // clear wins over a coincident sample
        state_q   <= ST_ACQUIRE;
        valid_q   <= 1'b0;
        err_q     <= 1'b0;
        code_q    <= ERR_GLYPH;
        lap_cnt_q <= '0;
      end else if (sample_i) begin
        unique case (state_q)
          ST_ACQUIRE: begin
            if (frm_ok) begin
              col_q   <= frm_col;
              row_q   <= frm_row;
              state_q <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (frm_ok && is_hold) begin
              state_q <= ST_SYNC;
            end else if (frm_ok && sync_ok) begin
              col_q   <= frm_col;
              row_q   <= frm_row;
              dir_q   <= sync_dir_d;
              step_q  <= 1'b1;
              valid_q <= 1'b1;
              state_q <= ST_TRACK;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
              code_q  <= err_code_d;
            end
          end
          ST_TRACK: begin
            if (frm_ok && is_hold) begin
              state_q <= ST_TRACK;
            end else if (frm_ok && track_ok) begin
              col_q  <= frm_col;
              row_q  <= frm_row;
              step_q <= 1'b1;
              if (is_flip) dir_q <= ~dir_q;
              if (lap_turn) begin
                lap_q     <= 1'b1;
                lap_cnt_q <= lap_cnt_q + LAP_WIDTH'(1);
              end
            end else begin
              state_q <= ST_ERROR;
              valid_q <= 1'b0;
              err_q   <= 1'b1;
              code_q  <= err_code_d;
            end
          end
          default: state_q <= ST_ERROR;  // ERROR: samples ignored until clear
        endcase
      end
    end
  end

  assign valid_o     = valid_q;
  assign col_o       = col_q;
  assign row_o       = row_q;
  assign dir_o       = dir_q;
  assign step_o      = step_q;
  assign lap_o       = lap_q;
  assign lap_count_o = lap_cnt_q;
  assign error_o     = err_q;
  assign err_code_o  = code_q;

endmodule

// File: tb/tb_circle_decoder.sv
// Directed bench for circle_decoder: expected outputs are queued when a
// stimulus step is driven and popped/compared one cycle later.
module tb_circle_decoder;

  typedef logic [5:0][7:0] bus_t;

  typedef struct {
    logic        valid;
    logic [2:0]  col;
    logic        row, dir, step, lap;
    logic [15:0] cnt;
    logic        err;
    logic [1:0]  code;
    logic [8:0]  chk;   // 0 valid,1 col,2 row,3 dir,4 step,5 lap,6 cnt,7 err,8 code
  } exp_t;

  localparam logic [8:0] ALL    = 9'h1FF;
  localparam logic [8:0] NODIR  = 9'h1F7;
  localparam logic [8:0] NOSTEP = 9'h1EF;
  localparam logic [8:0] ERRM   = 9'h1F1;
  localparam logic [8:0] CLRM   = 9'h0F1;

  logic clk = 1'b0, rst = 1'b1, sample = 1'b0, clr = 1'b0;
  bus_t seg7;
  logic valid_o, row_o, dir_o, step_o, lap_o, error_o;
  logic [2:0]  col_o;
  logic [15:0] lap_count_o;
  logic [1:0]  err_code_o;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int pc[14];
  bit pr[14], pd[14];
  bus_t blank_bus, b;

  always #5 clk = ~clk;

  circle_decoder dut (
    .clk_i(clk), .rst_i(rst), .sample_i(sample), .clr_err_i(clr), .seg7_i(seg7),
    .valid_o(valid_o), .col_o(col_o), .row_o(row_o), .dir_o(dir_o),
    .step_o(step_o), .lap_o(lap_o), .lap_count_o(lap_count_o),
    .error_o(error_o), .err_code_o(err_code_o)
  );

  function automatic bus_t frame(input int col, input bit up);
    bus_t f;
    for (int i = 0; i < 6; i++) f[i] = 8'hFF;
    f[col] = up ? ~8'h63 : ~8'h5C;
    return f;
  endfunction

  function automatic exp_t mk(input logic v, input logic [2:0] c, input logic r, input logic d,
                              input logic s, input logic l, input logic [15:0] n,
                              input logic e, input logic [1:0] code, input logic [8:0] m);
    exp_t x;
    x.valid = v; x.col = c; x.row = r; x.dir = d; x.step = s; x.lap = l;
    x.cnt = n; x.err = e; x.code = code; x.chk = m;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    if (e.chk[0]) chk({tag, ".valid"}, 16'(valid_o),  16'(e.valid));
    if (e.chk[1]) chk({tag, ".col"},   16'(col_o),    16'(e.col));
    if (e.chk[2]) chk({tag, ".row"},   16'(row_o),    16'(e.row));
    if (e.chk[3]) chk({tag, ".dir"},   16'(dir_o),    16'(e.dir));
    if (e.chk[4]) chk({tag, ".step"},  16'(step_o),   16'(e.step));
    if (e.chk[5]) chk({tag, ".lap"},   16'(lap_o),    16'(e.lap));
    if (e.chk[6]) chk({tag, ".cnt"},   lap_count_o,   e.cnt);
    if (e.chk[7]) chk({tag, ".err"},   16'(error_o),  16'(e.err));
    if (e.chk[8]) chk({tag, ".code"},  16'(err_code_o), 16'(e.code));
  endtask

  // one stimulus cycle, result checked the cycle after
  task automatic drive(input string tag, input bus_t bus, input logic smp, input logic c,
                       input logic r, input exp_t e);
    @(posedge clk); #1;
    seg7 = bus; sample = smp; clr = c; rst = r;
    sb.push_back(e);
    @(posedge clk); #1;
    sample = 1'b0; clr = 1'b0; rst = 1'b0; seg7 = blank_bus;
    pop_check(tag);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) blank_bus[i] = 8'hFF;
    seg7 = blank_bus;
    // walk table: (0,up) (0,dn) (1..5,dn) (5,up) (4..0,up) (0,dn)
    pc[0] = 0; pr[0] = 1; pd[0] = 0;
    pc[1] = 0; pr[1] = 0; pd[1] = 1;
    for (int i = 1; i <= 5; i++) begin pc[1+i] = i;     pr[1+i] = 0; pd[1+i] = 1; end
    pc[7] = 5; pr[7] = 1; pd[7] = 0;
    for (int i = 1; i <= 5; i++) begin pc[7+i] = 5 - i; pr[7+i] = 1; pd[7+i] = 0; end
    pc[13] = 0; pr[13] = 0; pd[13] = 1;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL));
    pop_check("reset");

    // full lap
    for (int k = 0; k < 14; k++) begin
      exp_t e;
      if (k == 0)      e = mk(0, 3'(pc[k]), pr[k], 0, 0, 0, 0, 0, 0, NODIR);
      else if (k == 1) e = mk(1, 3'(pc[k]), pr[k], pd[k], 0, 0, 0, 0, 0, NOSTEP);
      else             e = mk(1, 3'(pc[k]), pr[k], pd[k], 1, k == 13, (k == 13) ? 16'd1 : 16'd0, 0, 0, ALL);
      drive($sformatf("walk%0d", k), frame(pc[k], pr[k]), 1, 0, 0, e);
    end

    // second lap, each frame held for three samples
    for (int k = 2; k < 14; k++)
      for (int r = 0; r < 3; r++)
        drive($sformatf("hold%0d_%0d", k, r), frame(pc[k], pr[k]), 1, 0, 0,
              mk(1, 3'(pc[k]), pr[k], pd[k], r == 0, (k == 13) && (r == 0),
                 (k == 13) ? 16'd2 : 16'd1, 0, 0, ALL));

    // jump from (2,dn,dir=1) to (4,dn)
    drive("to1", frame(1, 0), 1, 0, 0, mk(1, 1, 0, 1, 1, 0, 2, 0, 0, ALL));
    drive("to2", frame(2, 0), 1, 0, 0, mk(1, 2, 0, 1, 1, 0, 2, 0, 0, ALL));
    drive("jump", frame(4, 0), 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 3, ERRM));
    drive("errhold", frame(3, 0), 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 2, 1, 3, ERRM));
    drive("clr1", blank_bus, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));
    // coincident clear and sample: the (1,up) frame must be discarded
    drive("clrsmp", frame(1, 1), 1, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));
    drive("acq4", frame(4, 0), 1, 0, 0, mk(0, 4, 0, 0, 0, 0, 0, 0, 0, NODIR));

    // two upper circles
    b = blank_bus; b[1] = ~8'h63; b[3] = ~8'h63;
    drive("multi", b, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, ERRM));
    drive("clr2", blank_bus, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));

    // all segments lit on one digit: ignored in ACQUIRE, GLYPH error in SYNC
    b = blank_bus; b[2] = 8'h00;
    drive("glyph_acq", b, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));
    drive("acq2u", frame(2, 1), 1, 0, 0, mk(0, 2, 1, 0, 0, 0, 0, 0, 0, NODIR));
    drive("glyph", b, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, ERRM));
    drive("clr3", blank_bus, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));

    // blank bus while tracking
    drive("acq3u", frame(3, 1), 1, 0, 0, mk(0, 3, 1, 0, 0, 0, 0, 0, 0, NODIR));
    drive("trk2u", frame(2, 1), 1, 0, 0, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, NOSTEP));
    drive("none", blank_bus, 1, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 1, 2, ERRM));
    drive("clr4", blank_bus, 0, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, CLRM));

    // reset mid-walk, then resync from (3,up)
    drive("r0u", frame(0, 1), 1, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, NODIR));
    drive("r0d", frame(0, 0), 1, 0, 0, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, NOSTEP));
    drive("r1d", frame(1, 0), 1, 0, 0, mk(1, 1, 0, 1, 1, 0, 0, 0, 0, ALL));
    drive("rst", frame(2, 0), 1, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, ALL));
    drive("rs3u", frame(3, 1), 1, 0, 0, mk(0, 3, 1, 0, 0, 0, 0, 0, 0, ALL));
    drive("rs2u", frame(2, 1), 1, 0, 0, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, NOSTEP));
    // no strobe: state holds, pulses stay low
    drive("idle", frame(5, 0), 0, 0, 0, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, ALL));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
